// File: rtl/stack_controller_if.sv
// Bundles the CPU request, context-burst, status and stack-datapath signals of stack_controller.
// slave is the controller's view; master is the surrounding system's view.
interface stack_controller_if;
  logic        cpu_push;
  logic        cpu_pop;
  logic [31:0] cpu_d;
  logic        cpu_stall;
  logic        ctx_save;
  logic        ctx_restore;
  logic [4:0]  ctx_len;
  logic [3:0]  ctx_widx;
  logic [31:0] ctx_wdata;
  logic [31:0] ctx_rdata;
  logic        ctx_rvalid;
  logic        busy;
  logic        done;
  logic [7:0]  count;
  logic        err_ovf;
  logic        err_unf;
  logic        clr_err;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_d;
  logic [31:0] stk_q;

  modport slave (
    input  cpu_push, cpu_pop, cpu_d, ctx_save, ctx_restore, ctx_len, ctx_wdata, clr_err, stk_q,
    output cpu_stall, ctx_widx, ctx_rdata, ctx_rvalid, busy, done, count, err_ovf, err_unf,
    output stk_push, stk_pop, stk_d
  );

  modport master (
    output cpu_push, cpu_pop, cpu_d, ctx_save, ctx_restore, ctx_len, ctx_wdata, clr_err, stk_q,
    input  cpu_stall, ctx_widx, ctx_rdata, ctx_rvalid, busy, done, count, err_ovf, err_unf,
    input  stk_push, stk_pop, stk_d
  );
endinterface

// File: rtl/stack_controller.sv
// Arbitrates single-word CPU push/pop against multi-word context save/restore bursts
// onto an external 32-bit stack datapath, tracking occupancy and sticky error flags.
module stack_controller #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned MAXBURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  stack_controller_if.slave bus
);
  localparam logic [8:0] DepthW = 9'(DEPTH);
  localparam logic [4:0] MaxLen = 5'(MAXBURST);

  typedef enum logic [1:0] {StIdle, StSave, StRestore} state_e;

  state_e     state_q;
  logic [3:0] idx_q;
  logic [3:0] last_q;
  logic [7:0] count_q;
  logic       done_q;
  logic       err_ovf_q;
  logic       err_unf_q;

  logic       idle, in_save, in_restore, start, len_ok, cpu_req, cpu_go;
  logic       save_ok, rest_ok, set_ovf, set_unf, cpu_push_op, cpu_pop_op;
  logic       push, pop;
  logic [8:0] save_total;

  always_comb begin
    idle        = (state_q == StIdle);
    in_save     = (state_q == StSave);
    in_restore  = (state_q == StRestore);
    start       = idle & ~reset & (bus.ctx_save | bus.ctx_restore);
    len_ok      = (bus.ctx_len != 5'd0) && (bus.ctx_len <= MaxLen);
    save_total  = {1'b0, count_q} + {4'b0, bus.ctx_len};
    // Save has priority, so a restore is only considered when ctx_save is low.
    save_ok     = start & bus.ctx_save & len_ok & (save_total <= DepthW);
    rest_ok     = start & ~bus.ctx_save & len_ok & ({3'b0, bus.ctx_len} <= count_q);
    cpu_req     = ~reset & (bus.cpu_push | bus.cpu_pop);
    // Push and pop together cancel out: neither executes nor stalls.
    cpu_go      = idle & ~start & ~reset & (bus.cpu_push ^ bus.cpu_pop);
    cpu_push_op = cpu_go & bus.cpu_push & ({1'b0, count_q} < DepthW);
    cpu_pop_op  = cpu_go & bus.cpu_pop & (count_q != 8'd0);
    set_ovf     = (start & bus.ctx_save & len_ok & (save_total > DepthW))
                | (cpu_go & bus.cpu_push & ~cpu_push_op);
    set_unf     = (start & ~bus.ctx_save & len_ok & ({3'b0, bus.ctx_len} > count_q))
                | (cpu_go & bus.cpu_pop & ~cpu_pop_op);
    push        = in_save | cpu_push_op;
    pop         = in_restore | cpu_pop_op;
  end

  always_comb begin
    bus.stk_push   = push;
    bus.stk_pop    = pop;
    bus.stk_d      = in_save ? bus.ctx_wdata : (cpu_push_op ? bus.cpu_d : 32'h0);
    bus.cpu_stall  = cpu_req & (~idle | start);
    bus.ctx_widx   = idx_q;
    bus.ctx_rvalid = in_restore;
    bus.ctx_rdata  = in_restore ? bus.stk_q : 32'h0;
    bus.busy       = ~idle;
    bus.done       = done_q;
    bus.count      = count_q;
    bus.err_ovf    = err_ovf_q;
    bus.err_unf    = err_unf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      last_q    <= 4'd0;
      count_q   <= 8'd0;
      done_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      count_q   <= count_q + {7'd0, push} - {7'd0, pop};
      err_ovf_q <= set_ovf | (err_ovf_q & ~bus.clr_err);
      err_unf_q <= set_unf | (err_unf_q & ~bus.clr_err);
      unique case (state_q)
        StIdle: begin
          if (start && !len_ok) begin
            done_q <= 1'b1;
          end else if (save_ok) begin
            state_q <= StSave;
            idx_q   <= 4'd0;
            last_q  <= 4'(bus.ctx_len - 5'd1);
          end else if (rest_ok) begin
            state_q <= StRestore;
            idx_q   <= 4'(bus.ctx_len - 5'd1);
          end
        end
        StSave: begin
          if (idx_q == last_q) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        StRestore: begin
          if (idx_q == 4'd0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: vector table, directed burst/error/reset sequences and a
// randomized run compared cycle by cycle against a queue-based reference model.
module tb_stack_controller;
  localparam int Depth    = 128;
  localparam int MaxBurst = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_controller_if bus ();

  stack_controller #(
    .DEPTH    (Depth),
    .MAXBURST (MaxBurst)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stack datapath stand-in: cleared by the same reset as the controller.
  logic [31:0] mem [0:255];
  int          sp;
  always @(posedge clk or posedge reset) begin
    if (reset) sp <= 0;
    else if (bus.stk_push && sp < 256) begin
      mem[sp] <= bus.stk_d;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) sp <= sp - 1;
  end
  assign bus.stk_q = (sp > 0) ? mem[sp-1] : 32'h0;

  logic [31:0] wd_base;
  always_comb bus.ctx_wdata = wd_base + {28'h0, bus.ctx_widx};

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [31:0] m_stack [$];
  int          m_mode;  // 0 idle, 1 saving, 2 restoring
  int          m_len, m_left;
  bit          m_done, m_ovf, m_unf;

  bit          e_push, e_pop, e_stall, e_busy, e_done, e_ovf, e_unf, e_rvalid;
  logic [31:0] e_d, e_rdata, e_top;
  int          e_widx, e_count;

  logic        a_push, a_pop, a_stall, a_busy, a_done, a_ovf, a_unf, a_rvalid;
  logic [31:0] a_d, a_rdata, a_q;
  logic [3:0]  a_widx;
  logic [7:0]  a_count;

  typedef struct {
    bit push, pop, save, restore, clr;
    logic [4:0]  len;
    logic [31:0] d;
    bit x_push, x_pop, x_stall, x_busy, x_done, x_unf;
    int x_count;
  } vec_t;
  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    bus.cpu_push = 0; bus.cpu_pop = 0; bus.cpu_d = 0; bus.ctx_save = 0;
    bus.ctx_restore = 0; bus.ctx_len = 0; bus.clr_err = 0;
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_mode = 0; m_len = 0; m_left = 0; m_done = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_eval();
    bit req, st;
    int sz;
    sz  = m_stack.size();
    req = bus.cpu_push | bus.cpu_pop;
    st  = (m_mode == 0) && (bus.ctx_save || bus.ctx_restore);
    e_push = 0; e_pop = 0; e_d = 0; e_widx = 0; e_rvalid = 0; e_rdata = 0; e_top = 0;
    e_stall = req && (m_mode != 0 || st);
    e_busy = (m_mode != 0); e_done = m_done; e_count = sz; e_ovf = m_ovf; e_unf = m_unf;
    if (sz > 0) e_top = m_stack[sz-1];
    if (m_mode == 1) begin
      e_push = 1; e_widx = m_len - m_left; e_d = wd_base + 32'(e_widx);
    end else if (m_mode == 2) begin
      e_pop = 1; e_widx = m_left - 1; e_rvalid = 1; e_rdata = e_top;
    end else if (!st && bus.cpu_push && !bus.cpu_pop && sz < Depth) begin
      e_push = 1; e_d = bus.cpu_d;
    end else if (!st && bus.cpu_pop && !bus.cpu_push && sz > 0) begin
      e_pop = 1;
    end
  endtask

  task automatic model_commit();
    bit n_ovf, n_unf, n_done;
    int sz, l;
    n_ovf = 0; n_unf = 0; n_done = 0;
    sz = m_stack.size();
    l  = int'(bus.ctx_len);
    if (m_mode == 1) begin
      m_stack.push_back(e_d);
      m_left--;
      if (m_left == 0) begin m_mode = 0; n_done = 1; end
    end else if (m_mode == 2) begin
      void'(m_stack.pop_back());
      m_left--;
      if (m_left == 0) begin m_mode = 0; n_done = 1; end
    end else if (bus.ctx_save || bus.ctx_restore) begin
      if (l == 0 || l > MaxBurst) n_done = 1;
      else if (bus.ctx_save) begin
        if (sz + l > Depth) n_ovf = 1;
        else begin m_mode = 1; m_len = l; m_left = l; end
      end else begin
        if (l > sz) n_unf = 1;
        else begin m_mode = 2; m_len = l; m_left = l; end
      end
    end else if (bus.cpu_push && !bus.cpu_pop) begin
      if (sz < Depth) m_stack.push_back(bus.cpu_d);
      else n_ovf = 1;
    end else if (bus.cpu_pop && !bus.cpu_push) begin
      if (sz > 0) void'(m_stack.pop_back());
      else n_unf = 1;
    end
    m_ovf  = n_ovf || (m_ovf && !bus.clr_err);
    m_unf  = n_unf || (m_unf && !bus.clr_err);
    m_done = n_done;
  endtask

  // One clock cycle: inputs already driven; sample on the falling edge, then advance.
  task automatic do_cycle();
    model_eval();
    @(negedge clk);
    a_push = bus.stk_push; a_pop = bus.stk_pop; a_stall = bus.cpu_stall; a_busy = bus.busy;
    a_done = bus.done; a_ovf = bus.err_ovf; a_unf = bus.err_unf; a_rvalid = bus.ctx_rvalid;
    a_d = bus.stk_d; a_rdata = bus.ctx_rdata; a_q = bus.stk_q; a_widx = bus.ctx_widx;
    a_count = bus.count;
    chk("stk_push", a_push, e_push);
    chk("stk_pop", a_pop, e_pop);
    chk("cpu_stall", a_stall, e_stall);
    chk("stk_d", a_d, e_d);
    chk("ctx_widx", a_widx, e_widx);
    chk("ctx_rvalid", a_rvalid, e_rvalid);
    chk("ctx_rdata", a_rdata, e_rdata);
    chk("busy", a_busy, e_busy);
    chk("done", a_done, e_done);
    chk("count", a_count, e_count);
    chk("err_ovf", a_ovf, e_ovf);
    chk("err_unf", a_unf, e_unf);
    if (e_pop && !e_rvalid) chk("stk_q", a_q, e_top);
    model_commit();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic do_reset();
    reset = 1; clr_in();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    //        push pop sav rst clr len    d       xpush xpop xstl xbsy xdn xunf cnt
    vt[0]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,  0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 0, 5'd0,  32'h11, 1, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 0, 0, 0, 0, 5'd0,  32'h22, 1, 0, 0, 0, 0, 0, 1};
    vt[3]  = '{1, 1, 0, 0, 0, 5'd0,  32'h33, 0, 0, 0, 0, 0, 0, 2};
    vt[4]  = '{0, 1, 0, 0, 0, 5'd0,  32'h0,  0, 1, 0, 0, 0, 0, 2};
    vt[5]  = '{0, 1, 0, 0, 0, 5'd0,  32'h0,  0, 1, 0, 0, 0, 0, 1};
    vt[6]  = '{0, 1, 0, 0, 0, 5'd0,  32'h0,  0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,  0, 0, 0, 0, 0, 1, 0};
    vt[8]  = '{0, 0, 0, 0, 1, 5'd0,  32'h0,  0, 0, 0, 0, 0, 1, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 5'd0,  32'h0,  0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{1, 0, 1, 0, 0, 5'd0,  32'h44, 0, 0, 1, 0, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 5'd0,  32'h0,  0, 0, 0, 0, 1, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 5'd0,  32'h0,  0, 0, 0, 0, 0, 0, 0};
    vt[13] = '{0, 0, 0, 1, 0, 5'd17, 32'h0,  0, 0, 0, 0, 0, 0, 0};
    vt[14] = '{0, 0, 0, 0, 0, 5'd0,  32'h0,  0, 0, 0, 0, 1, 0, 0};

    wd_base = 32'h0;
    model_reset();
    reset = 1; clr_in();
    repeat (2) @(posedge clk);
    #1;
    bus.cpu_push = 1; bus.ctx_save = 1; bus.ctx_len = 5'd4;
    #1;
    chk("rst_stk_push", bus.stk_push, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_err", {bus.err_ovf, bus.err_unf, bus.done}, 0);
    clr_in();
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 15; i++) begin
      bus.cpu_push = vt[i].push; bus.cpu_pop = vt[i].pop; bus.ctx_save = vt[i].save;
      bus.ctx_restore = vt[i].restore; bus.clr_err = vt[i].clr; bus.ctx_len = vt[i].len;
      bus.cpu_d = vt[i].d;
      do_cycle();
      chk($sformatf("vec%0d_push", i), a_push, vt[i].x_push);
      chk($sformatf("vec%0d_pop", i), a_pop, vt[i].x_pop);
      chk($sformatf("vec%0d_stall", i), a_stall, vt[i].x_stall);
      chk($sformatf("vec%0d_busy", i), a_busy, vt[i].x_busy);
      chk($sformatf("vec%0d_done", i), a_done, vt[i].x_done);
      chk($sformatf("vec%0d_unf", i), a_unf, vt[i].x_unf);
      chk($sformatf("vec%0d_count", i), a_count, vt[i].x_count);
    end

    // Single push/pop round trip
    do_reset();
    bus.cpu_push = 1; bus.cpu_d = 32'hA5A5A5A5;
    do_cycle();
    chk("rt_push", a_push, 1);
    bus.cpu_pop = 1;
    do_cycle();
    chk("rt_pop", a_pop, 1);
    chk("rt_stk_q", a_q, 32'hA5A5A5A5);
    chk("rt_count1", a_count, 1);
    do_cycle();
    chk("rt_count0", a_count, 0);
    chk("rt_noerr", {a_ovf, a_unf}, 0);

    // Save 4 then restore 4
    do_reset();
    wd_base = 32'h10;
    bus.ctx_save = 1; bus.ctx_len = 5'd4;
    do_cycle();
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      chk($sformatf("sv%0d_push", i), a_push, 1);
      chk($sformatf("sv%0d_widx", i), a_widx, i);
      chk($sformatf("sv%0d_d", i), a_d, 32'h10 + i);
    end
    do_cycle();
    chk("sv_done", a_done, 1);
    chk("sv_count", a_count, 4);
    bus.ctx_restore = 1; bus.ctx_len = 5'd4;
    do_cycle();
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      chk($sformatf("rs%0d_rvalid", i), a_rvalid, 1);
      chk($sformatf("rs%0d_widx", i), a_widx, 3 - i);
      chk($sformatf("rs%0d_rdata", i), a_rdata, 32'h13 - i);
    end
    do_cycle();
    chk("rs_done", a_done, 1);
    chk("rs_count", a_count, 0);

    // Save and restore together: save wins
    bus.ctx_save = 1; bus.ctx_restore = 1; bus.ctx_len = 5'd2;
    do_cycle();
    do_cycle();
    chk("both_push", a_push, 1);
    do_cycle();
    do_cycle();
    chk("both_done", a_done, 1);
    chk("both_count", a_count, 2);

    // Restore longer than occupancy
    bus.ctx_restore = 1; bus.ctx_len = 5'd3;
    do_cycle();
    chk("unf_nopop", a_pop, 0);
    do_cycle();
    chk("unf_flag", a_unf, 1);
    chk("unf_nodone", a_done, 0);
    chk("unf_count", a_count, 2);
    chk("unf_busy", a_busy, 0);

    // Fill to DEPTH, overflow, clear
    do_reset();
    for (int i = 0; i < Depth; i++) begin
      bus.cpu_push = 1; bus.cpu_d = 32'(i);
      do_cycle();
    end
    bus.cpu_push = 1; bus.cpu_d = 32'hDEAD;
    do_cycle();
    chk("ovf_nopush", a_push, 0);
    chk("ovf_count", a_count, Depth);
    bus.cpu_push = 1; bus.clr_err = 1;
    do_cycle();
    chk("ovf_flag", a_ovf, 1);
    do_cycle();
    chk("ovf_clr_vs_set", a_ovf, 1);
    bus.clr_err = 1;
    do_cycle();
    do_cycle();
    chk("ovf_cleared", a_ovf, 0);
    chk("ovf_count_hold", a_count, Depth);

    // CPU push during a save burst stalls
    do_reset();
    bus.cpu_push = 1; bus.cpu_d = 32'h7;
    do_cycle();
    bus.ctx_save = 1; bus.ctx_len = 5'd4; bus.cpu_push = 1;
    do_cycle();
    chk("stall_start", a_stall, 1);
    for (int i = 0; i < 4; i++) begin
      bus.cpu_push = 1; bus.cpu_d = 32'h99;
      do_cycle();
      chk($sformatf("stall_save%0d", i), a_stall, 1);
    end
    do_cycle();
    chk("stall_done", a_done, 1);
    chk("stall_count", a_count, 5);

    // Reset in the third SAVE cycle of an 8-word burst
    do_reset();
    bus.ctx_save = 1; bus.ctx_len = 5'd8;
    do_cycle();
    do_cycle();
    do_cycle();
    reset = 1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_count", bus.count, 0);
    chk("abort_push", bus.stk_push, 0);
    chk("abort_widx", bus.ctx_widx, 0);
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      chk($sformatf("abort_nodone%0d", i), a_done, 0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus.cpu_d = $urandom;
      if (r < ((n < 1500) ? 55 : 25)) bus.cpu_push = 1;
      else if (r < 75) bus.cpu_pop = 1;
      else if (r < 80) begin bus.cpu_push = 1; bus.cpu_pop = 1; end
      r = int'($urandom_range(0, 99));
      if (r < 4) bus.ctx_save = 1;
      else if (r < 8) bus.ctx_restore = 1;
      else if (r < 9) begin bus.ctx_save = 1; bus.ctx_restore = 1; end
      bus.ctx_len = 5'($urandom_range(0, 20));
      bus.clr_err = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) wd_base = $urandom;
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
